// File: rtl/wb_pkg.sv
// Shared widths and helpers for the write-back stage and its pending-write scoreboard.
package wb_pkg;

  localparam int DATA_W   = 16;
  localparam int REG_AW   = 3;
  localparam int NUM_REGS = 1 << REG_AW;
  localparam int PEND_W   = 2;
  localparam int CNT_W    = 16;

  // Register 0 reads as zero, so it never holds a pending write.
  localparam int R0_IDX = 0;

  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  typedef struct packed {
    logic              en;
    logic [REG_AW-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_req_t;

  function automatic logic writes_reg(input logic              valid,
                                      input logic              wr,
                                      input logic [REG_AW-1:0] dest);
    return valid & wr & (dest != REG_AW'(R0_IDX));
  endfunction

endpackage

// File: rtl/wb_scoreboard.sv
// Per-register saturating pending-write counters; busy_mask_o is decoded from
// the counter registers only, so decode sees no combinational path from inputs.
module wb_scoreboard
  import wb_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                issue_valid_i,
  input  logic [REG_AW-1:0]   issue_dest_i,
  input  logic                retire_valid_i,
  input  logic [REG_AW-1:0]   retire_addr_i,
  input  logic                flush_i,
  output logic [NUM_REGS-1:0] busy_mask_o,
  output logic                overflow_o
);

  logic [NUM_REGS-1:0] sat_hit;
  logic                overflow_q;
  logic                overflow_d;

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
    if (gi == R0_IDX) begin : g_zero
      assign busy_mask_o[gi] = 1'b0;
      assign sat_hit[gi]     = 1'b0;
    end else begin : g_cnt
      logic [PEND_W-1:0] pend_q;
      logic [PEND_W-1:0] pend_d;
      logic              inc;
      logic              dec;

      assign inc = issue_valid_i  && (issue_dest_i  == REG_AW'(gi));
      assign dec = retire_valid_i && (retire_addr_i == REG_AW'(gi));

      // Issue and retire to the same register in one cycle cancel out.
      always_comb begin
        pend_d = pend_q;
        if (flush_i) begin
          pend_d = '0;
        end else if (inc && !dec) begin
          if (pend_q != PEND_MAX) pend_d = pend_q + 1'b1;
        end else if (dec && !inc) begin
          if (pend_q != '0) pend_d = pend_q - 1'b1;
        end
      end

      assign sat_hit[gi] = !flush_i && inc && !dec && (pend_q == PEND_MAX);

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) pend_q <= '0;
        else      pend_q <= pend_d;
      end

      assign busy_mask_o[gi] = |pend_q;
    end
  end

  assign overflow_d = overflow_q | (|sat_hit);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) overflow_q <= 1'b0;
    else      overflow_q <= overflow_d;
  end

  assign overflow_o = overflow_q;

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: registers the MEM result onto the register-file write port,
// counts committed writes and tracks in-flight writes for decode hazard checks.
module wb_stage
  import wb_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                mem_valid,
  input  logic                mem_wr,
  input  logic                mem_is_load,
  input  logic [REG_AW-1:0]   mem_dest,
  input  logic [DATA_W-1:0]   mem_alu_result,
  input  logic [DATA_W-1:0]   mem_load_data,
  input  logic                issue_valid,
  input  logic                issue_wr,
  input  logic [REG_AW-1:0]   issue_dest,
  input  logic                flush,
  output logic                wb_wr_en,
  output logic [REG_AW-1:0]   wb_addr,
  output logic [DATA_W-1:0]   wb_data,
  output logic [NUM_REGS-1:0] busy_mask,
  output logic [CNT_W-1:0]    retire_cnt,
  output logic                sb_overflow
);

  wb_req_t          wb_q;
  wb_req_t          wb_d;
  logic [CNT_W-1:0] retire_cnt_q;
  logic [CNT_W-1:0] retire_cnt_d;
  logic             mem_commit;
  logic             issue_commit;

  assign mem_commit   = writes_reg(mem_valid, mem_wr, mem_dest) && !flush;
  assign issue_commit = writes_reg(issue_valid, issue_wr, issue_dest);

  // Address and data hold when idle; the counter includes the write now on the port.
  always_comb begin
    wb_d         = wb_q;
    wb_d.en      = mem_commit;
    retire_cnt_d = retire_cnt_q;
    if (mem_commit) begin
      wb_d.addr    = mem_dest;
      wb_d.data    = mem_is_load ? mem_load_data : mem_alu_result;
      retire_cnt_d = retire_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_q         <= '0;
      retire_cnt_q <= '0;
    end else begin
      wb_q         <= wb_d;
      retire_cnt_q <= retire_cnt_d;
    end
  end

  wb_scoreboard u_scoreboard (
    .clk            (clk),
    .rst            (rst),
    .issue_valid_i  (issue_commit),
    .issue_dest_i   (issue_dest),
    .retire_valid_i (wb_q.en),
    .retire_addr_i  (wb_q.addr),
    .flush_i        (flush),
    .busy_mask_o    (busy_mask),
    .overflow_o     (sb_overflow)
  );

  assign wb_wr_en   = wb_q.en;
  assign wb_addr    = wb_q.addr;
  assign wb_data    = wb_q.data;
  assign retire_cnt = retire_cnt_q;

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: directed scenarios followed by random traffic,
// checked against a pending-count model of the register write pipeline.
module tb_wb_stage;
  import wb_pkg::*;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic                mem_valid = 0, mem_wr = 0, mem_is_load = 0;
  logic [REG_AW-1:0]   mem_dest = '0;
  logic [DATA_W-1:0]   mem_alu_result = '0, mem_load_data = '0;
  logic                issue_valid = 0, issue_wr = 0;
  logic [REG_AW-1:0]   issue_dest = '0;
  logic                flush = 0;
  logic                wb_wr_en;
  logic [REG_AW-1:0]   wb_addr;
  logic [DATA_W-1:0]   wb_data;
  logic [NUM_REGS-1:0] busy_mask;
  logic [15:0]         retire_cnt;
  logic                sb_overflow;

  wb_stage dut (
    .clk(clk), .rst(rst),
    .mem_valid(mem_valid), .mem_wr(mem_wr), .mem_is_load(mem_is_load),
    .mem_dest(mem_dest), .mem_alu_result(mem_alu_result), .mem_load_data(mem_load_data),
    .issue_valid(issue_valid), .issue_wr(issue_wr), .issue_dest(issue_dest),
    .flush(flush),
    .wb_wr_en(wb_wr_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .busy_mask(busy_mask), .retire_cnt(retire_cnt), .sb_overflow(sb_overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit mv, mw, ml; int md; int alu, ld;
    bit iv, iw; int id; bit fl;
  } stim_t;

  typedef struct { int addr; int data; } wr_t;

  int   checks = 0;
  int   errors = 0;
  wr_t  exp_q[$];
  bit   mon_on = 0;

  // Reference model: pending-write counts per register and the expected port.
  int    pend[NUM_REGS];
  bit    m_ovf, m_en;
  int    m_rcnt, m_addr, m_data;
  stim_t applied;
  stim_t idle_s;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < NUM_REGS; i++) pend[i] = 0;
    m_ovf = 0; m_en = 0; m_rcnt = 0; m_addr = 0; m_data = 0;
  endfunction

  function automatic bit commits(input stim_t s);
    return s.mv && s.mw && (s.md != 0) && !s.fl;
  endfunction

  function automatic void model_step(input stim_t s);
    bit old_en   = m_en;
    int old_addr = m_addr;
    int maxc     = (1 << PEND_W) - 1;
    m_en = commits(s);
    if (m_en) begin
      m_addr = s.md;
      m_data = s.ml ? s.ld : s.alu;
      m_rcnt = (m_rcnt + 1) % 65536;
    end
    for (int r = 1; r < NUM_REGS; r++) begin
      bit inc = s.iv && s.iw && (s.id == r);
      bit dec = old_en && (old_addr == r);
      if (s.fl)                 pend[r] = 0;
      else if (inc && !dec) begin
        if (pend[r] == maxc)    m_ovf = 1;
        else                    pend[r]++;
      end else if (dec && !inc && pend[r] > 0) pend[r]--;
    end
  endfunction

  function automatic logic [NUM_REGS-1:0] exp_busy();
    logic [NUM_REGS-1:0] b = '0;
    for (int r = 0; r < NUM_REGS; r++) b[r] = (pend[r] != 0);
    return b;
  endfunction

  function automatic stim_t st(input bit mv, input bit mw, input bit ml, input int md,
                               input int alu, input int ld, input bit iv, input bit iw,
                               input int id, input bit fl);
    stim_t s;
    s.mv = mv; s.mw = mw; s.ml = ml; s.md = md; s.alu = alu; s.ld = ld;
    s.iv = iv; s.iw = iw; s.id = id; s.fl = fl;
    return s;
  endfunction

  task automatic apply(input stim_t s);
    wr_t w;
    mem_valid = s.mv; mem_wr = s.mw; mem_is_load = s.ml;
    mem_dest = REG_AW'(s.md);
    mem_alu_result = DATA_W'(s.alu); mem_load_data = DATA_W'(s.ld);
    issue_valid = s.iv; issue_wr = s.iw; issue_dest = REG_AW'(s.id);
    flush = s.fl;
    applied = s;
    if (commits(s)) begin
      w.addr = s.md;
      w.data = s.ml ? s.ld : s.alu;
      exp_q.push_back(w);
    end
  endtask

  // Advance past one edge, account for what that edge consumed, then drive s.
  task automatic step(input stim_t s);
    @(posedge clk); #1;
    if (rst) model_step(applied);
    apply(s);
  endtask

  task automatic wr(input int d, input bit ld, input int v);
    step(st(1, 1, ld, d, ld ? 16'h0 : v, ld ? v : 16'h0, 0, 0, 0, 0));
  endtask

  task automatic iss(input int d);
    step(st(0, 0, 0, 0, 0, 0, 1, 1, d, 0));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(idle_s);
  endtask

  // Caller has just driven a committing write; drop reset while it sits on the port.
  task automatic mid_reset();
    step(idle_s);
    check("pre_reset_wr_en", wb_wr_en, m_en);
    #2 rst = 1'b0;
    #1;
    check("rst_wr_en", wb_wr_en, 0);
    check("rst_addr", wb_addr, 0);
    check("rst_data", wb_data, 0);
    check("rst_busy", busy_mask, 0);
    check("rst_rcnt", retire_cnt, 0);
    check("rst_ovf", sb_overflow, 0);
    model_reset();
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b1;
    apply(idle_s);
  endtask

  always @(negedge clk) begin : monitor
    wr_t e;
    if (mon_on && rst) begin
      check("wr_en", wb_wr_en, m_en);
      if (wb_wr_en) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL spurious_write: got addr %0d data 0x%0h expected no write", wb_addr, wb_data);
        end else begin
          e = exp_q.pop_front();
          check("wb_addr", wb_addr, e.addr);
          check("wb_data", wb_data, e.data);
        end
        $display("wb write r%0d=0x%04h busy=0x%02h ovf=%0d retire_cnt=%0d",
                 wb_addr, wb_data, busy_mask, sb_overflow, retire_cnt);
      end else begin
        check("hold_addr", wb_addr, m_addr);
        check("hold_data", wb_data, m_data);
      end
      check("busy_mask", busy_mask, exp_busy());
      check("sb_overflow", sb_overflow, m_ovf);
      check("retire_cnt", retire_cnt, m_rcnt);
    end
  end

  initial begin
    stim_t s;
    idle_s = st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    applied = idle_s;
    model_reset();
    #12;
    check("init_wr_en", wb_wr_en, 0);
    check("init_addr", wb_addr, 0);
    check("init_data", wb_data, 0);
    check("init_busy", busy_mask, 0);
    check("init_rcnt", retire_cnt, 0);
    check("init_ovf", sb_overflow, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    mon_on = 1;

    wr(3, 0, 16'h1234); idle(1);
    check("t1_en", wb_wr_en, 1); check("t1_addr", wb_addr, 3);
    check("t1_data", wb_data, 16'h1234); check("t1_rcnt", retire_cnt, 1);
    wr(5, 1, 16'hBEEF); idle(1);
    check("t2_addr", wb_addr, 5); check("t2_data", wb_data, 16'hBEEF);
    wr(0, 0, 16'h7777); idle(1);
    check("t2_r0_en", wb_wr_en, 0); check("t2_r0_rcnt", retire_cnt, 2);

    iss(2); iss(2); idle(1);
    check("cnt_busy2", busy_mask, 8'h04);
    wr(2, 0, 16'h0002); idle(3);
    check("cnt_busy1", busy_mask, 8'h04);
    wr(2, 0, 16'h0003); idle(3);
    check("cnt_busy0", busy_mask, 8'h00);
    iss(2); iss(2); iss(2); iss(2); idle(1);
    check("ovf_set", sb_overflow, 1); check("ovf_busy", busy_mask, 8'h04);
    step(st(0, 0, 0, 0, 0, 0, 0, 0, 0, 1)); idle(1);
    check("flush_clear", busy_mask, 8'h00);

    iss(4); wr(4, 0, 16'h4444); iss(4); idle(1);
    check("same_cycle_busy4", busy_mask[4], 1);
    wr(4, 0, 16'h4445); idle(2);
    check("retire_only_busy4", busy_mask[4], 0);

    iss(1); iss(2); iss(3);
    step(st(1, 1, 0, 1, 16'hDEAD, 0, 1, 1, 5, 1));
    check("pre_flush_busy", busy_mask, 8'h0E);
    idle(1);
    check("flush_busy", busy_mask, 8'h00); check("flush_wr_en", wb_wr_en, 0);
    check("flush_rcnt", retire_cnt, 6); check("flush_ovf", sb_overflow, 1);

    wr(6, 0, 16'h55AA);
    mid_reset();
    idle(1);
    check("post_reset_rcnt", retire_cnt, 0);

    for (int n = 0; n < 600; n++) begin
      if (n % 200 == 199) begin
        wr(1 + $urandom_range(0, 6), 0, $urandom_range(0, 65535));
        mid_reset();
      end else begin
        s = st($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 1),
               $urandom_range(0, 7), $urandom_range(0, 65535), $urandom_range(0, 65535),
               $urandom_range(0, 1), $urandom_range(0, 3) != 0, $urandom_range(0, 7),
               $urandom_range(0, 19) == 0);
        step(s);
      end
    end
    idle(4);
    check("queue_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Write-back stage of the 16-bit pipeline: the writer end of the register-file port that the decode stage reads from.
- Registers the MEM-stage result and selects ALU result or load data.
- Drives the register file's write port (wr_en/address/data) one cycle later.
- Keeps a per-register pending-write scoreboard so decode can detect RAW hazards against in-flight writes.

Parameters:
- DATA_W, 16, register/data width
- REG_AW, 3, register address width
- NUM_REGS, 8, register count (2**REG_AW)
- PEND_W, 2, width of each per-register pending counter

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- mem_valid  in  1  MEM stage presents a retiring instruction this cycle
- mem_wr  in  1  instruction writes a register
- mem_is_load  in  1  1 = write mem_load_data, 0 = write mem_alu_result
- mem_dest  in  REG_AW  destination register
- mem_alu_result  in  DATA_W  ALU result
- mem_load_data  in  DATA_W  data memory read data
- issue_valid  in  1  decode issues an instruction this cycle
- issue_wr  in  1  issued instruction writes a register
- issue_dest  in  REG_AW  its destination
- flush  in  1  pipeline flush (branch/reset of younger ops)
- wb_wr_en  out  1  register-file write enable
- wb_addr  out  REG_AW  register-file write address
- wb_data  out  DATA_W  register-file write data
- busy_mask  out  NUM_REGS  bit i = register i has a pending write
- retire_cnt  out  16  committed-write counter
- sb_overflow  out  1  sticky: issue to a register whose counter is saturated

Behaviour:
- Reset (rst low, asynchronous):
  - wb_wr_en=0, wb_addr=0, wb_data=0.
  - All pending counters=0, so busy_mask=0.
  - retire_cnt=0, sb_overflow=0.
- Pipeline register (latency 1):
  - On edge with mem_valid & mem_wr & mem_dest!=0 & !flush: wb_wr_en=1, wb_addr=mem_dest.
  - wb_data = mem_is_load ? mem_load_data : mem_alu_result.
  - Otherwise wb_wr_en=0; wb_addr/wb_data hold their previous values.
  - Register 0 is hardwired zero: writes to dest 0 never assert wb_wr_en, never touch the scoreboard, and do not count.
- Retire: every cycle wb_wr_en=1 is one retirement of wb_addr. retire_cnt increments by 1 per retirement and wraps 0xFFFF->0x0000.
- Scoreboard: one PEND_W-bit counter per register, r1..r7 used.
  - Increment when issue_valid & issue_wr & issue_dest!=0.
  - Decrement when wb_wr_en=1 for that register.
  - Both same cycle, same register: counter unchanged.
  - Issue at max (3) and no simultaneous retire: counter stays 3, sb_overflow set.
  - Retire with counter 0: counter stays 0 (no underflow).
  - busy_mask[i] = (counter[i]!=0); busy_mask[0] always 0; registered, no combinational path from inputs.
- Flush (synchronous, highest priority):
  - Next edge: all counters=0, wb_wr_en=0, mem-stage input discarded, issue in same cycle ignored.
  - retire_cnt and sb_overflow unaffected.
  - A write already on wb_* outputs during the flush cycle still completes in the register file.
- sb_overflow clears only on reset.
- Reset asserted mid-operation: all state returns to reset values immediately; an in-progress write is dropped.

Decomposition:
- Shared package: DATA_W, REG_AW, NUM_REGS constants; the R0 index constant.
- One sub-module, wb_scoreboard: the pending-counter array.
  - Inputs: issue, retire, flush.
  - Outputs: busy_mask, overflow.
- wb_stage holds the pipeline register, result mux and retire counter.

Test Plan:
- Reset, then mem_valid=1, mem_wr=1, mem_dest=3, mem_is_load=0, mem_alu_result=0x1234 -> next cycle wb_wr_en=1, wb_addr=3, wb_data=0x1234; retire_cnt=1.
- Same with mem_is_load=1, mem_load_data=0xBEEF, dest 5 -> wb_data=0xBEEF, wb_addr=5. Then dest 0 -> wb_wr_en=0, retire_cnt unchanged.
- Counter sequence and overflow:
  - Issue dest 2 twice -> busy_mask=0x04.
  - One retire of r2 -> still 0x04; second retire -> 0x00.
  - Issue r2 four times -> sb_overflow=1, counter stays 3.
- Simultaneous issue and retire:
  - Pending counter r4=1; issue r4 and retire r4 in the same cycle -> busy_mask[4] stays 1.
  - Then retire only -> busy_mask[4]=0.
- Flush:
  - busy_mask=0x0E with mem_valid write pending; assert flush -> next cycle busy_mask=0, wb_wr_en=0.
  - retire_cnt and sb_overflow keep their values.
- Reset mid-operation:
  - Drop rst while wb_wr_en=1 -> outputs 0 within the same cycle, no clock edge needed.
  - After release, retire_cnt=0.
